// File: rtl/axi_chan_pipe.sv
// axi_chan_pipe: configurable chain of valid/ready register slices for one AXI channel.
// Each slice is either a 2-entry skid buffer (registered ready) or a 1-entry pipe register
// (combinational ready). Adds a synchronous flush and a registered occupancy count.
module axi_chan_pipe #(
   parameter int WIDTH     = 32,
   parameter int STAGES    = 2,
   parameter bit READY_REG = 1'b1,
   localparam int CAP      = STAGES * (READY_REG ? 2 : 1),
   localparam int OCC_W    = (CAP == 0) ? 1 : $clog2(CAP + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             s_valid,
   output logic             s_ready,
   input  logic [WIDTH-1:0] s_data,
   output logic             m_valid,
   input  logic             m_ready,
   output logic [WIDTH-1:0] m_data,
   output logic [OCC_W-1:0] occupancy
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } skid_state_e;

   generate
      if (STAGES == 0) begin : g_bypass
         assign m_valid   = s_valid;
         assign m_data    = s_data;
         assign s_ready   = m_ready;
         assign occupancy = '0;
      end else begin : g_chain
         // Index k is the link feeding slice k; index STAGES is the m_* side.
         logic             vld   [0:STAGES];
         logic             rdy   [0:STAGES];
         logic [WIDTH-1:0] dat   [0:STAGES];
         logic [1:0]       cnt_n [0:STAGES-1];
         logic [STAGES-1:0] full;
         logic [OCC_W-1:0] occ_q;
         logic [OCC_W-1:0] occ_n;

         assign vld[0]      = s_valid;
         assign dat[0]      = s_data;
         assign s_ready     = rdy[0];
         assign m_valid     = vld[STAGES];
         assign m_data      = dat[STAGES];
         assign rdy[STAGES] = m_ready;
         assign occupancy   = occ_q;

         for (genvar k = 0; k < STAGES; k++) begin : g_slice
            if (READY_REG) begin : g_skid
               skid_state_e      state_q;
               skid_state_e      state_n;
               logic [WIDTH-1:0] main_q;
               logic [WIDTH-1:0] skid_q;
               logic             in_hs;
               logic             out_hs;
               logic             load_main;
               logic             load_skid;
               logic             pop_skid;

               assign rdy[k]     = (state_q != TWO);
               assign full[k]    = (state_q != EMPTY);
               assign vld[k+1]   = full[k];
               assign dat[k+1]   = main_q;
               assign cnt_n[k]   = (state_n == TWO) ? 2'd2 : ((state_n == ONE) ? 2'd1 : 2'd0);

               // Next-state and storage-enable decode for the skid slice
               always_comb begin
                  state_n   = state_q;
                  load_main = 1'b0;
                  load_skid = 1'b0;
                  pop_skid  = 1'b0;
                  in_hs     = vld[k] && (state_q != TWO);
                  out_hs    = (state_q != EMPTY) && rdy[k+1];
                  case (state_q)
                     EMPTY: begin
                        if (in_hs) begin
                           state_n   = ONE;
                           load_main = 1'b1;
                        end
                     end
                     ONE: begin
                        if (in_hs && out_hs) begin
                           load_main = 1'b1;
                        end else if (in_hs) begin
                           state_n   = TWO;
                           load_skid = 1'b1;
                        end else if (out_hs) begin
                           state_n   = EMPTY;
                        end
                     end
                     TWO: begin
                        if (out_hs) begin
                           state_n  = ONE;
                           pop_skid = 1'b1;
                        end
                     end
                     default: state_n = EMPTY;
                  endcase
                  if (flush) state_n = EMPTY;
               end

               // Slice state register
               always_ff @(posedge clk or negedge rst_n) begin
                  if (!rst_n) state_q <= EMPTY;
                  else        state_q <= state_n;
               end

               // Payload registers, deliberately without reset
               always_ff @(posedge clk) begin
                  if (load_main)     main_q <= dat[k];
                  else if (pop_skid) main_q <= skid_q;
                  if (load_skid)     skid_q <= dat[k];
               end
            end else begin : g_pipe
               logic             valid_q;
               logic             valid_n;
               logic             in_hs;
               logic [WIDTH-1:0] data_q;

               // Ready folded as "m_ready or any slice from here onward is empty",
               // equivalent to !valid | next_ready chained, but with no feedback through rdy[].
               assign rdy[k]   = m_ready | ~(&full[STAGES-1:k]);
               assign full[k]  = valid_q;
               assign vld[k+1] = valid_q;
               assign dat[k+1] = data_q;
               assign cnt_n[k] = {1'b0, valid_n};

               // Valid update for the pipe slice
               always_comb begin
                  valid_n = valid_q;
                  in_hs   = vld[k] && rdy[k];
                  if (in_hs)                     valid_n = 1'b1;
                  else if (valid_q && rdy[k+1])  valid_n = 1'b0;
                  if (flush)                     valid_n = 1'b0;
               end

               // Valid register
               always_ff @(posedge clk or negedge rst_n) begin
                  if (!rst_n) valid_q <= 1'b0;
                  else        valid_q <= valid_n;
               end

               // Payload register, deliberately without reset
               always_ff @(posedge clk) begin
                  if (in_hs) data_q <= dat[k];
               end
            end
         end

         // Sum of next-cycle entry counts across all slices
         always_comb begin
            occ_n = '0;
            for (int unsigned i = 0; i < unsigned'(STAGES); i++) begin
               occ_n = occ_n + OCC_W'(cnt_n[i]);
            end
         end

         // Occupancy register
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) occ_q <= '0;
            else        occ_q <= occ_n;
         end
      end
   endgenerate

endmodule

// File: doc/axi_chan_pipe.md
# axi_chan_pipe

Parametrised valid/ready pipeline for one AXI channel, such as the instruction-fetch read-address path with `arvalid`/`arready`. It replaces chains of plain wire buffers on long top-to-core routes with a configurable number of register slices. The slices break the forward path (`valid`/`data`) and, optionally, the backward path (`ready`) while keeping full throughput. It adds a synchronous flush and a live occupancy count, which a plain buffer chain does not have.

## Interface
- `WIDTH`, default 32: payload bits per beat, 1..512.
- `STAGES`, default 2: number of register slices, 0..8. 0 = combinational pass-through.
- `READY_REG`, default 1:
  - 1: each slice is a 2-entry skid buffer, so `ready` is registered.
  - 0: each slice is a 1-entry pipe register, so `ready` is combinational through the chain.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `flush` input 1: synchronous clear of all stored beats.
- `s_valid` input 1: upstream beat valid.
- `s_ready` output 1: upstream beat accepted when `s_valid & s_ready`.
- `s_data` input `WIDTH`: upstream payload.
- `m_valid` output 1: downstream beat valid.
- `m_ready` input 1: downstream accept.
- `m_data` output `WIDTH`: downstream payload.
- `occupancy` output `OCC_W`: count of beats held.
  - `OCC_W = $clog2(CAP+1)`, minimum 1.
  - `CAP = STAGES*(READY_REG?2:1)`.

## Operation
- Slice *k* takes its input from slice *k-1*; slice 0 takes its input from the `s_*` side. The last slice drives the `m_*` side.
- **Skid slice (`READY_REG=1`).** States are EMPTY, ONE and TWO. Storage is `main`, plus `skid`.
  - `out_valid` = state≠EMPTY.
  - `out_data` = `main`.
  - `in_ready` is a register, equal to state≠TWO.
  - EMPTY: in → ONE, and `main` ← in.
  - ONE:
    - in and out → ONE, and `main` ← in.
    - in only → TWO, and `skid` ← in.
    - out only → EMPTY.
  - TWO: out → ONE, and `main` ← `skid`. No input is accepted in TWO.
- **Pipe slice (`READY_REG=0`).**
  - `in_ready = !valid | out_ready`.
  - On an input handshake: `valid` ← 1 and `data` ← in.
  - Else on an output handshake: `valid` ← 0.
- **`STAGES=0`.**
  - `m_valid=s_valid`, `m_data=s_data`, `s_ready=m_ready`.
  - `occupancy=0`; `flush` is ignored.
- **`occupancy`.** Registered sum of the held entries across all slices. Updated every edge. Never exceeds `CAP`.
- **`flush`.** At the edge where `flush=1`:
  - Every slice goes to EMPTY (or `valid` 0).
  - A beat accepted upstream in that cycle is discarded.
  - A downstream handshake in that cycle still counts as delivered.
  - `s_ready` is 1 in the following cycle.
- **AXI stability.** While `m_valid & !m_ready`, `m_valid` and `m_data` hold.
- **Ordering.** No beat is duplicated, dropped (except by flush) or reordered.
- **Reset.** Payload registers are not reset; only state and valid bits are.

## Timing
- Reset values, asynchronous on `rst_n` low:
  - `m_valid=0`.
  - `occupancy=0`.
  - `s_ready=1` in skid mode.
  - All slices EMPTY.
- Reset deassertion mid-transfer: nothing is delivered from before the reset.
- Latency, `s` handshake to `m_valid`: `STAGES` cycles when empty downstream.
- Throughput: 1 beat/cycle sustained with `m_ready=1` in both modes.
- Skid mode: `s_ready` falls only after `CAP` beats are stalled.
  - `m_ready` has no combinational path to `s_ready`.
  - `s_*` has no combinational path to `m_*`.
- Pipe mode: `m_ready` reaches `s_ready` combinationally through all slices. A full chain with `m_ready=1` accepts and delivers in the same cycle.
- Simultaneous accept and deliver on a slice keeps its occupancy unchanged.

## Test plan
- **Streaming, skid 2 stages.** WIDTH=32, STAGES=2, READY_REG=1; reset, then stream 0x1..0x10 with `m_ready=1`.
  - First `m_valid` at cycle 2 after the first accept.
  - 16 beats arrive in order, one per cycle.
  - `s_ready` stays 1 throughout.
- **Backpressure.** Hold `m_ready=0` while pushing 0xA0..0xA5.
  - Exactly 4 are accepted; `s_ready` is 0 after the 4th; `occupancy=4`.
  - `m_data=0xA0` stable.
  - Release `m_ready`: 0xA0..0xA3 out, then 0xA4 and 0xA5; `occupancy` returns to 0.
- **Flush.** Fill 3 beats, then pulse `flush` in a cycle with `s_valid=1`, data 0xFF.
  - Next cycle: `m_valid=0`, `occupancy=0`, `s_ready=1`.
  - 0xFF is never delivered.
- **Pipe mode, full chain.** READY_REG=0, STAGES=3; fill, then `m_ready=1` with continuous input.
  - `s_ready=1` in the same cycle.
  - `occupancy` stays at 3.
  - Output order is preserved.
- **Asynchronous reset.** Drive `rst_n` low between edges with 2 beats held.
  - `m_valid` and `occupancy` go to 0 immediately, with no clock edge.
  - After release the first beat out is a new one.
- **Pass-through.** STAGES=0; random `s_valid`/`m_ready` for 1000 cycles.
  - `m_*` equals `s_*` and `s_ready` equals `m_ready` in every cycle.
  - `occupancy=0`.
